player_controller: RTL

PLAYER_CONTROLLER -- requirements
Module: player_controller

---
 rtl/player_controller.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/player_controller.sv
// Sprite motion controller: synchronizes three buttons and, once per frame step,
// moves the player horizontally and runs a GROUNDED/RISING/FALLING jump FSM.
module player_controller #(
  parameter int SCREEN_W = 640,
  parameter int PLAYER_W = 16,
  parameter int GROUND_Y = 400,
  parameter int X_INIT   = 312,
  parameter int SPEED    = 4,
  parameter int JUMP_V   = 12,
  parameter int GRAVITY  = 1,
  parameter int MAX_FALL = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       left_button,
  input  logic       right_button,
  input  logic       jump,
  output logic [9:0] player_x,
  output logic [9:0] player_y,
  output logic       airborne,
  output logic       update_done
);

  localparam int VY_W  = 5;
  localparam int X_MAX = SCREEN_W - PLAYER_W;

  typedef logic signed [11:0] calc_t;
  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  localparam calc_t SPEED_S  = calc_t'(SPEED);
  localparam calc_t X_MAX_S  = calc_t'(X_MAX);
  localparam calc_t GROUND_S = calc_t'(GROUND_Y);
  localparam calc_t GRAV_S   = calc_t'(GRAVITY);
  localparam calc_t MFALL_S  = calc_t'(MAX_FALL);

  // Arithmetic is done 12-bit signed so under/overflow clamps instead of wrapping.
  function automatic logic [9:0] clamp_pos(input calc_t v, input calc_t hi);
    if (v < calc_t'(0))
      clamp_pos = '0;
    else if (v > hi)
      clamp_pos = hi[9:0];
    else
      clamp_pos = v[9:0];
  endfunction

  function automatic calc_t min_s(input calc_t a, input calc_t b);
    min_s = (a < b) ? a : b;
  endfunction

  logic [2:0]      btn_p0, btn_p1;
  logic            tick_p0;
  logic            step;
  logic            btn_l, btn_r, btn_j;
  logic            j_prev_p1;
  logic            vld_p1;
  state_t          state_p1, state_nxt;
  logic [9:0]      x_p1, y_p1, x_nxt, y_nxt;
  logic [VY_W-1:0] vy_p1, vy_nxt;
  calc_t           x_s, y_s, vy_s, nv;

  assign btn_l = btn_p1[2];
  assign btn_r = btn_p1[1];
  assign btn_j = btn_p1[0];
  assign step  = frame_tick & ~tick_p0;

  assign x_s  = signed'({2'b00, x_p1});
  assign y_s  = signed'({2'b00, y_p1});
  assign vy_s = signed'({{(12-VY_W){1'b0}}, vy_p1});
  assign nv   = min_s(vy_s + GRAV_S, MFALL_S);

  // Stage p0/p1: button synchronizers (stored active-high) and tick history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_p0    <= '0;
      btn_p1    <= '0;
      tick_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      j_prev_p1 <= 1'b0;
      state_p1  <= GROUNDED;
      x_p1      <= X_INIT[9:0];
      y_p1      <= GROUND_Y[9:0];
      vy_p1     <= '0;
    end else begin
      btn_p0  <= {~left_button, ~right_button, ~jump};
      btn_p1  <= btn_p0;
      tick_p0 <= frame_tick;
      vld_p1  <= step;
      if (step) begin
        state_p1  <= state_nxt;
        x_p1      <= x_nxt;
        y_p1      <= y_nxt;
        vy_p1     <= vy_nxt;
        j_prev_p1 <= btn_j;
      end
    end
  end

  always_comb begin
    state_nxt = state_p1;
    x_nxt     = x_p1;
    y_nxt     = y_p1;
    vy_nxt    = vy_p1;

    if (btn_l && !btn_r)
      x_nxt = clamp_pos(x_s - SPEED_S, X_MAX_S);
    else if (btn_r && !btn_l)
      x_nxt = clamp_pos(x_s + SPEED_S, X_MAX_S);

    case (state_p1)
      GROUNDED: begin
        if (btn_j && !j_prev_p1) begin
          state_nxt = RISING;
          vy_nxt    = VY_W'(JUMP_V);
        end
      end
      RISING: begin
        y_nxt = clamp_pos(y_s - vy_s, GROUND_S);
        // Apex: the last upward move uses the old vy, then the fall starts from rest.
        if (vy_s <= GRAV_S) begin
          state_nxt = FALLING;
          vy_nxt    = '0;
        end else begin
          vy_nxt = VY_W'(vy_s - GRAV_S);
        end
      end
      FALLING: begin
        if (y_s + nv >= GROUND_S) begin
          state_nxt = GROUNDED;
          y_nxt     = GROUND_S[9:0];
          vy_nxt    = '0;
        end else begin
          y_nxt  = clamp_pos(y_s + nv, GROUND_S);
          vy_nxt = VY_W'(nv);
        end
      end
      default: state_nxt = GROUNDED;
    endcase
  end

  assign player_x    = x_p1;
  assign player_y    = y_p1;
  assign airborne    = (state_p1 != GROUNDED);
  assign update_done = vld_p1;

endmodule
